// File: rtl/pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_stall_controller
// Description : Hazard/stall control for a 5-stage pipeline. Arbitrates
//               memory-wait holds, taken-branch flushes and load-use stalls
//               (Mealy outputs), with a sticky memory-wait watchdog.
//               Optional macro STALL_PERF_EN adds saturating 16-bit
//               load-stall and memory-stall cycle counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_stall_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_ex_mem_read,
    input  logic [4:0] if_id_rs1,
    input  logic [4:0] if_id_rs2,
    input  logic [4:0] id_ex_rd,
    input  logic       branch_taken,
    input  logic       dmem_req,
    input  logic       dmem_ready,
    output logic       pc_write,
    output logic       if_id_write,
    output logic       if_id_flush,
    output logic       id_ex_flush,
    output logic       pipe_hold,
    output logic       mem_timeout
`ifdef STALL_PERF_EN
    ,
    output logic [15:0] load_stall_cnt,
    output logic [15:0] mem_stall_cnt
`endif
);

    localparam logic [0:0] c_RUN      = 1'b0;
    localparam logic [0:0] c_MEM_WAIT = 1'b1;
    localparam logic [7:0] c_CNT_MAX  = 8'hFF;

    logic [0:0] r_state;
    logic [7:0] r_waitCnt;
    logic       r_memTimeout;

    logic       w_memHold;
    logic       w_branch;
    logic       w_loadUse;
    logic       w_loadStall;

    // A memory hold is a new miss in RUN, or any not-ready cycle while waiting
    assign w_memHold   = (r_state == c_RUN) ? (dmem_req & ~dmem_ready) : ~dmem_ready;
    // rd of x0 never matches, so x0 sources can never stall
    assign w_loadUse   = id_ex_mem_read && (id_ex_rd != 5'd0) &&
                         ((id_ex_rd == if_id_rs1) || (id_ex_rd == if_id_rs2));
    assign w_branch    = ~w_memHold & branch_taken;
    assign w_loadStall = ~w_memHold & ~branch_taken & w_loadUse;

    // Priority-resolved control outputs; all forced low while reset is held
    always_comb begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        pipe_hold   = 1'b0;
        if (rst_n) begin
            if (w_memHold) begin
                pipe_hold   = 1'b1;
            end else if (w_branch) begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (w_loadStall) begin
                id_ex_flush = 1'b1;
            end else begin
                pc_write    = 1'b1;
                if_id_write = 1'b1;
            end
        end
    end

    // State register: wait while memory is holding, otherwise run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_RUN;
        end else begin
            r_state <= w_memHold ? c_MEM_WAIT : c_RUN;
        end
    end

    // Wait counter: cleared on entry to MEM_WAIT, saturating count of waiting cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_waitCnt <= 8'd0;
        end else if ((r_state == c_RUN) && w_memHold) begin
            r_waitCnt <= 8'd0;
        end else if ((r_state == c_MEM_WAIT) && w_memHold && (r_waitCnt != c_CNT_MAX)) begin
            r_waitCnt <= r_waitCnt + 8'd1;
        end
    end

    // Sticky watchdog flag; only reset clears it, the FSM keeps waiting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_memTimeout <= 1'b0;
        end else if (r_waitCnt == c_CNT_MAX) begin
            r_memTimeout <= 1'b1;
        end
    end

    assign mem_timeout = r_memTimeout;

`ifdef STALL_PERF_EN
    logic [15:0] r_loadStallCnt;
    logic [15:0] r_memStallCnt;

    // Saturating performance counters for load-use and memory-hold cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_loadStallCnt <= 16'd0;
            r_memStallCnt  <= 16'd0;
        end else begin
            if (w_loadStall && (r_loadStallCnt != 16'hFFFF)) begin
                r_loadStallCnt <= r_loadStallCnt + 16'd1;
            end
            if (w_memHold && (r_memStallCnt != 16'hFFFF)) begin
                r_memStallCnt <= r_memStallCnt + 16'd1;
            end
        end
    end

    assign load_stall_cnt = r_loadStallCnt;
    assign mem_stall_cnt  = r_memStallCnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipeline_stall_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_stall_controller
// Description : Scoreboard bench for pipeline_stall_controller. Expected
//               outputs come from a small behavioural model, are queued when
//               stimulus is driven and compared on the following negedge.
//               Define STALL_PERF_EN to also check the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_controller;

    logic       clk;
    logic       rst_n;
    logic       id_ex_mem_read;
    logic [4:0] if_id_rs1;
    logic [4:0] if_id_rs2;
    logic [4:0] id_ex_rd;
    logic       branch_taken;
    logic       dmem_req;
    logic       dmem_ready;
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_flush;
    logic       pipe_hold;
    logic       mem_timeout;
`ifdef STALL_PERF_EN
    logic [15:0] load_stall_cnt;
    logic [15:0] mem_stall_cnt;
`endif

    pipeline_stall_controller dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_ex_mem_read (id_ex_mem_read),
        .if_id_rs1      (if_id_rs1),
        .if_id_rs2      (if_id_rs2),
        .id_ex_rd       (id_ex_rd),
        .branch_taken   (branch_taken),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .if_id_flush    (if_id_flush),
        .id_ex_flush    (id_ex_flush),
        .pipe_hold      (pipe_hold),
        .mem_timeout    (mem_timeout)
`ifdef STALL_PERF_EN
        ,
        .load_stall_cnt (load_stall_cnt),
        .mem_stall_cnt  (mem_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Expected output vectors {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout}
    logic [5:0] expQ[$];
    string      tagQ[$];

    // Reference model state
    bit mWait;
    int mCnt;
    bit mTimeout;
    int mLoadCnt;
    int mMemCnt;

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] outVec();
        return {pc_write, if_id_write, if_id_flush, id_ex_flush, pipe_hold, mem_timeout};
    endfunction

    task automatic modelReset();
        mWait    = 1'b0;
        mCnt     = 0;
        mTimeout = 1'b0;
        mLoadCnt = 0;
        mMemCnt  = 0;
    endtask

    // One clock of stimulus: drive, queue expectation, compare at negedge, advance model
    task automatic step(input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic br, input logic rq,
                        input logic rdy, input string tag);
        logic       hold;
        logic       lu;
        logic       bra;
        logic       lst;
        logic [4:0] e;
        @(posedge clk);
        #1;
        id_ex_mem_read = mr;
        id_ex_rd       = rd;
        if_id_rs1      = rs1;
        if_id_rs2      = rs2;
        branch_taken   = br;
        dmem_req       = rq;
        dmem_ready     = rdy;
        hold = mWait ? !rdy : (rq && !rdy);
        lu   = mr && (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
        bra  = !hold && br;
        lst  = !hold && !bra && lu;
        if (hold)      e = 5'b00001;
        else if (bra)  e = 5'b11110;
        else if (lst)  e = 5'b00010;
        else           e = 5'b11000;
        expQ.push_back({e, mTimeout});
        tagQ.push_back(tag);
        @(negedge clk);
        checkValue(tagQ.pop_front(), {26'd0, outVec()}, {26'd0, expQ.pop_front()});
`ifdef STALL_PERF_EN
        checkValue({tag, "_loadcnt"}, {16'd0, load_stall_cnt}, mLoadCnt);
        checkValue({tag, "_memcnt"},  {16'd0, mem_stall_cnt},  mMemCnt);
`endif
        if (mCnt == 255) mTimeout = 1'b1;
        if (!mWait && hold) mCnt = 0;
        else if (mWait && hold && mCnt < 255) mCnt++;
        if (hold && mMemCnt < 65535) mMemCnt++;
        if (lst && mLoadCnt < 65535) mLoadCnt++;
        mWait = hold;
    endtask

    initial begin
        rst_n          = 1'b0;
        id_ex_mem_read = 1'b0;
        if_id_rs1      = 5'd0;
        if_id_rs2      = 5'd0;
        id_ex_rd       = 5'd0;
        branch_taken   = 1'b0;
        dmem_req       = 1'b0;
        dmem_ready     = 1'b1;
        modelReset();

        // Reset state: everything low while rst_n is held
        repeat (2) @(negedge clk);
        checkValue("reset_outs", {26'd0, outVec()}, 32'd0);
`ifdef STALL_PERF_EN
        checkValue("reset_cnts", {load_stall_cnt, mem_stall_cnt}, 32'd0);
`endif
        rst_n = 1'b1;

        // Normal flow, load-use on rs2, bubble cycle, load-use on rs1, x0 case
        step(0, 5'd0, 5'd1, 5'd2, 0, 0, 1, "normal");
        step(1, 5'd5, 5'd3, 5'd5, 0, 0, 1, "loaduse_rs2");
        step(0, 5'd0, 5'd3, 5'd5, 0, 0, 1, "bubble_normal");
        step(1, 5'd9, 5'd9, 5'd1, 0, 0, 1, "loaduse_rs1");
        step(1, 5'd0, 5'd0, 5'd4, 0, 0, 1, "x0_nostall");
        step(1, 5'd7, 5'd6, 5'd8, 0, 0, 1, "load_nohit");
        step(0, 5'd5, 5'd5, 5'd5, 0, 0, 1, "nonload_hit");

        // Branch alone and branch together with a load-use hit
        step(0, 5'd0, 5'd1, 5'd2, 1, 0, 1, "branch");
        step(1, 5'd5, 5'd5, 5'd2, 1, 0, 1, "branch_over_lu");

        // Memory wait: ready low for 3 cycles, branch ignored mid-wait, then release
        step(0, 5'd0, 5'd1, 5'd2, 0, 1, 0, "mem_enter");
        step(0, 5'd0, 5'd1, 5'd2, 1, 1, 0, "mem_wait_br");
        step(1, 5'd5, 5'd5, 5'd2, 0, 1, 0, "mem_wait_lu");
        step(1, 5'd5, 5'd5, 5'd2, 0, 1, 1, "mem_release_lu");
        step(0, 5'd0, 5'd1, 5'd2, 0, 0, 1, "after_mem");
        step(0, 5'd0, 5'd1, 5'd2, 1, 1, 1, "req_ready_br");

        // Watchdog: 260 not-ready cycles, then ready; flag must persist
        for (int i = 0; i < 260; i++) begin
            step(0, 5'd0, 5'd1, 5'd2, 0, 1, 0, $sformatf("wd_wait%0d", i));
        end
        checkValue("wd_flag_set", {31'd0, mem_timeout}, 32'd1);
        step(0, 5'd0, 5'd1, 5'd2, 0, 1, 1, "wd_release");
        step(0, 5'd0, 5'd1, 5'd2, 0, 0, 1, "wd_after");
        checkValue("wd_sticky", {31'd0, mem_timeout}, 32'd1);

        // Re-enter MEM_WAIT and abort with an asynchronous reset mid-cycle
        step(0, 5'd0, 5'd1, 5'd2, 0, 1, 0, "pre_rst_enter");
        step(0, 5'd0, 5'd1, 5'd2, 0, 1, 0, "pre_rst_wait");
        @(posedge clk);
        #3;
        dmem_req   = 1'b0;
        dmem_ready = 1'b1;
        rst_n      = 1'b0;
        #1;
        checkValue("async_rst_outs", {26'd0, outVec()}, 32'd0);
`ifdef STALL_PERF_EN
        checkValue("async_rst_cnts", {load_stall_cnt, mem_stall_cnt}, 32'd0);
`endif
        modelReset();
        @(negedge clk);
        rst_n = 1'b1;

        // First cycles after reset follow RUN rules
        step(0, 5'd0, 5'd1, 5'd2, 0, 0, 1, "post_rst_normal");
        step(1, 5'd3, 5'd3, 5'd0, 0, 0, 1, "post_rst_lu");
        step(0, 5'd0, 5'd1, 5'd2, 0, 1, 1, "post_rst_req_rdy");

        checkValue("queue_drained", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
